// File: rtl/sub_flag_stage.sv
// Subtract-checker stage: captures a/b/y, derives NZCV flags and an error bit,
// buffers results in a 2-entry FIFO, and counts signed-overflow transactions.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    upstream handshake carrying a, b, y
//   out_valid/out_ready  downstream handshake for out_y/out_flags/out_err
//   out_flags            {N,Z,C,V} of the head entry
//   ovf_count            saturating count of accepted V=1 transactions
//   clr_count            synchronous clear of ovf_count
module sub_flag_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_y,
    output logic [3:0]  out_flags,
    output logic        out_err,
    output logic [7:0]  ovf_count,
    input  logic        clr_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    typedef struct packed {
        logic [31:0] y;
        logic [3:0]  flags;
        logic        err;
    } entry_t;

    occ_t        occ;
    occ_t        occ_nxt;
    entry_t      mem [2];
    entry_t      new_e;
    entry_t      head;
    logic        wr_ptr;
    logic        rd_ptr;
    logic        push;
    logic        pop;
    logic [31:0] diff;

    // rst_n gates in_ready so nothing is offered while reset is held.
    assign in_ready  = rst_n && (occ != FULL);
    assign out_valid = (occ != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Flags come from the received y; err compares it against our own a-b.
    always_comb begin
        diff      = a - b;
        new_e.y   = y;
        new_e.flags = {
            y[31],
            (y == 32'd0),
            (a < b),
            (a[31] != b[31]) && (y[31] != a[31])
        };
        new_e.err = (y != diff);
    end

    always_comb begin
        occ_nxt = occ;
        unique case (occ)
            EMPTY: if (push) occ_nxt = ONE;
            ONE: begin
                if (push && !pop)
                    occ_nxt = FULL;
                else if (pop && !push)
                    occ_nxt = EMPTY;
            end
            FULL: if (pop) occ_nxt = ONE;
            default: occ_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ    <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            occ <= occ_nxt;
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
        end
    end

    // Payload needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= new_e;
    end

    assign head      = mem[rd_ptr];
    assign out_y     = out_valid ? head.y     : 32'd0;
    assign out_flags = out_valid ? head.flags : 4'd0;
    assign out_err   = out_valid ? head.err   : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_count <= 8'd0;
        else if (clr_count)
            ovf_count <= 8'd0;
        else if (push && new_e.flags[0] && (ovf_count != 8'hFF))
            ovf_count <= ovf_count + 8'd1;
    end

endmodule

// File: tb/tb_sub_flag_stage.sv
// Testbench for sub_flag_stage: vector table, directed corner sequences and
// random traffic checked against a queue-based reference model.
module tb_sub_flag_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic [3:0]  out_flags;
    logic        out_err;
    logic [7:0]  ovf_count;
    logic        clr_count;

    int checks = 0;
    int errors = 0;

    sub_flag_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_flags (out_flags),
        .out_err   (out_err),
        .ovf_count (ovf_count),
        .clr_count (clr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] y;
        logic [3:0]  f;
        logic        e;
    } ent_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic [3:0]  f;
        logic        e;
    } vec_t;

    ent_t q[$];
    int   m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ent_t ref_ent(input logic [31:0] ra,
                                     input logic [31:0] rb,
                                     input logic [31:0] ry);
        ent_t        r;
        logic [31:0] d;
        bit          sa, sb, sy;
        sa = (ra >= 32'h8000_0000);
        sb = (rb >= 32'h8000_0000);
        sy = (ry >= 32'h8000_0000);
        d  = ra - rb;
        r.y = ry;
        r.f = {sy, ry == 0, ra < rb, (sa != sb) && (sy != sa)};
        r.e = (ry != d);
        return r;
    endfunction

    task automatic drive(input logic iv, input logic [31:0] da,
                         input logic [31:0] db, input logic [31:0] dy,
                         input logic ordy, input logic clr);
        in_valid  = iv;
        a         = da;
        b         = db;
        y         = dy;
        out_ready = ordy;
        clr_count = clr;
    endtask

    task automatic compare_model();
        ent_t h;
        check("in_ready", in_ready, q.size() < 2);
        check("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            h = q[0];
        end else begin
            h.y = 0;
            h.f = 0;
            h.e = 0;
        end
        check("out_y", out_y, h.y);
        check("out_flags", out_flags, h.f);
        check("out_err", out_err, h.e);
        check("ovf_count", ovf_count, m_cnt);
    endtask

    // Compare, clock one edge, then advance the model with the same inputs.
    task automatic tick();
        bit   do_push, do_pop;
        ent_t n;
        compare_model();
        do_push = in_valid && (q.size() < 2);
        do_pop  = out_ready && (q.size() > 0);
        n = ref_ent(a, b, y);
        @(posedge clk);
        #1;
        if (do_pop)
            void'(q.pop_front());
        if (do_push)
            q.push_back(n);
        if (clr_count)
            m_cnt = 0;
        else if (do_push && n.f[0] && m_cnt < 255)
            m_cnt++;
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{32'hFFFF_FFFB, 32'h3, 32'hFFFF_FFF8, 4'b1000, 1'b0};
        vt[1] = '{32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b0001, 1'b0};
        vt[2] = '{32'h3, 32'h3, 32'h0, 4'b0100, 1'b0};
        vt[3] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 4'b1010, 1'b0};
        vt[4] = '{32'h5, 32'h2, 32'h4, 4'b0000, 1'b1};
        vt[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 4'b1011, 1'b0};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #3;
        check("rst in_ready", in_ready, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_y", out_y, 0);
        check("rst out_flags", out_flags, 0);
        check("rst ovf", ovf_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rel in_ready", in_ready, 1);

        // Vector table: single push into EMPTY, visible next cycle, then drain.
        for (int i = 0; i < 6; i++) begin
            drive(1, vt[i].a, vt[i].b, vt[i].y, 1, 0);
            tick();
            check("vec valid", out_valid, 1);
            check("vec y", out_y, vt[i].y);
            check("vec flags", out_flags, vt[i].f);
            check("vec err", out_err, vt[i].e);
            drive(0, 0, 0, 0, 1, 0);
            tick();
        end
        check("vec ovf", ovf_count, 2);

        // Backpressure: fill, hold off third, drain in order.
        drive(1, 32'h10, 32'h1, 32'hF, 0, 0);
        tick();
        drive(1, 32'h20, 32'h1, 32'h1F, 0, 0);
        tick();
        check("full in_ready", in_ready, 0);
        drive(1, 32'h30, 32'h1, 32'h2F, 0, 0);
        tick();
        tick();
        check("hold y", out_y, 32'hF);
        out_ready = 1'b1;
        tick();
        check("pop1 y", out_y, 32'h1F);
        check("pop1 in_ready", in_ready, 1);
        tick();
        check("pop2 y", out_y, 32'h2F);
        in_valid = 1'b0;
        tick();
        check("drained", out_valid, 0);

        // Saturation and clear priority.
        drive(0, 0, 0, 0, 1, 1);
        tick();
        for (int i = 0; i < 260; i++) begin
            drive(1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1, 0);
            tick();
        end
        check("sat ovf", ovf_count, 255);
        clr_count = 1'b1;
        tick();
        check("clr ovf", ovf_count, 0);
        drive(0, 0, 0, 0, 1, 0);
        tick();

        // Reset while FULL.
        drive(1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 0, 0);
        tick();
        drive(1, 32'h1234, 32'h34, 32'h1200, 0, 0);
        tick();
        check("pre-rst full", in_ready, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst valid", out_valid, 0);
        check("mid rst ovf", ovf_count, 0);
        check("mid rst y", out_y, 0);
        q.delete();
        m_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post rst ready", in_ready, 1);
        drive(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++)
            tick();

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] ra, rb, ry;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(3) == 0)
                ra = {1'b1, 31'($urandom_range(15))};
            ry = ($urandom_range(3) != 0) ? ra - rb : 32'($urandom);
            drive($urandom_range(1), ra, rb, ry, $urandom_range(1),
                  $urandom_range(31) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
